// File: rtl/averager_axil_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master port among NUM_REQ req/ack requesters.
// Define AXIL_ARB_TIMEOUT_EN to add a watchdog that ends a stalled access with SLVERR.
module averager_axil_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_W         = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    we,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*32-1:0] wdata,
  output logic [NUM_REQ-1:0]    ack,
  output logic [31:0]           rdata,
  output logic [1:0]            resp,
  output logic [NUM_REQ-1:0]    grant,
  output logic [ADDR_W-1:0]     M_AXI_AWADDR,
  output logic [2:0]            M_AXI_AWPROT,
  output logic                  M_AXI_AWVALID,
  input  logic                  M_AXI_AWREADY,
  output logic [31:0]           M_AXI_WDATA,
  output logic [3:0]            M_AXI_WSTRB,
  output logic                  M_AXI_WVALID,
  input  logic                  M_AXI_WREADY,
  input  logic [1:0]            M_AXI_BRESP,
  input  logic                  M_AXI_BVALID,
  output logic                  M_AXI_BREADY,
  output logic [ADDR_W-1:0]     M_AXI_ARADDR,
  output logic [2:0]            M_AXI_ARPROT,
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,
  input  logic [31:0]           M_AXI_RDATA,
  input  logic [1:0]            M_AXI_RRESP,
  input  logic                  M_AXI_RVALID,
  output logic                  M_AXI_RREADY
);

  localparam int PW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    IDLE, WADDR, WRESP, RADDR, RDATA, DONE
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [PW-1:0]       gidx_q, gidx_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [1:0]          resp_q, resp_d;

  logic                win_found;
  logic [PW-1:0]       win_idx;
  int                  scan;

  // First pending request at or above the pointer, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan = int'(ptr_q) + i;
      if (scan >= NUM_REQ) scan = scan - NUM_REQ;
      if (!win_found && req[scan]) begin
        win_found = 1'b1;
        win_idx   = PW'(scan);
      end
    end
  end

`ifdef AXIL_ARB_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                      $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [TW-1:0] tmo_q, tmo_d;
  logic          busy;
  logic          tmo_hit;

  always_comb begin
    busy    = (state_q == WADDR) || (state_q == WRESP) ||
              (state_q == RADDR) || (state_q == RDATA);
    tmo_d   = busy ? tmo_q + 1'b1 : '0;
    tmo_hit = busy && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`endif

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    gidx_d    = gidx_q;
    ptr_d     = ptr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    ack           = '0;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_BREADY  = 1'b0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          gidx_d    = win_idx;
          addr_d    = addr[int'(win_idx)*ADDR_W +: ADDR_W];
          wdata_d   = wdata[int'(win_idx)*32 +: 32];
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = we[win_idx] ? WADDR : RADDR;
        end
      end
      WADDR: begin
        M_AXI_AWVALID = !aw_done_q;
        M_AXI_WVALID  = !w_done_q;
        aw_done_d = aw_done_q | M_AXI_AWREADY;
        w_done_d  = w_done_q | M_AXI_WREADY;
        if (aw_done_d && w_done_d) state_d = WRESP;
      end
      WRESP: begin
        M_AXI_BREADY = 1'b1;
        if (M_AXI_BVALID) begin
          resp_d  = M_AXI_BRESP;
          rdata_d = '0;
          state_d = DONE;
        end
      end
      RADDR: begin
        M_AXI_ARVALID = 1'b1;
        if (M_AXI_ARREADY) state_d = RDATA;
      end
      RDATA: begin
        M_AXI_RREADY = 1'b1;
        if (M_AXI_RVALID) begin
          rdata_d = M_AXI_RDATA;
          resp_d  = M_AXI_RRESP;
          state_d = DONE;
        end
      end
      DONE: begin
        ack     = grant_q;
        grant_d = '0;
        ptr_d   = (int'(gidx_q) == NUM_REQ - 1) ? '0 : gidx_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef AXIL_ARB_TIMEOUT_EN
    if (tmo_hit) begin
      resp_d  = 2'b10;
      rdata_d = '0;
      state_d = DONE;
    end
`endif
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      gidx_q    <= '0;
      ptr_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      gidx_q    <= gidx_d;
      ptr_q     <= ptr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
    end
  end

  assign grant        = grant_q;
  assign rdata        = rdata_q;
  assign resp         = resp_q;
  assign M_AXI_AWADDR = addr_q;
  assign M_AXI_ARADDR = addr_q;
  assign M_AXI_WDATA  = wdata_q;
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;
  assign M_AXI_WSTRB  = 4'hF;

endmodule

// File: tb/tb_averager_axil_arbiter.sv
// Directed bench for averager_axil_arbiter with a small AXI4-Lite slave model.
// Slave readies have programmable delays; responses come one cycle after the address/data.
module tb_averager_axil_arbiter;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [1:0]  req, we;
  logic [7:0]  addr;
  logic [63:0] wdata;
  logic [1:0]  ack, grant, resp;
  logic [31:0] rdata;
  logic [3:0]  M_AXI_AWADDR, M_AXI_ARADDR;
  logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
  logic        M_AXI_AWVALID, M_AXI_AWREADY;
  logic [31:0] M_AXI_WDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_WVALID, M_AXI_WREADY;
  logic [1:0]  M_AXI_BRESP;
  logic        M_AXI_BVALID, M_AXI_BREADY;
  logic        M_AXI_ARVALID, M_AXI_ARREADY;
  logic [31:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;
  logic        M_AXI_RVALID, M_AXI_RREADY;

  int n_cmp = 0;
  int n_bad = 0;

  averager_axil_arbiter #(
    .NUM_REQ(2), .ADDR_W(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .resp(resp), .grant(grant),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
    .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  always #5 ACLK = ~ACLK;

  // Slave model
  int          aw_dly = 0, w_dly = 0, ar_dly = 0;
  int          aw_cnt, w_cnt, ar_cnt;
  logic        err_mode = 1'b0;
  logic        aw_got, w_got, ar_got;
  logic [3:0]  s_awa, s_ara;
  logic [31:0] s_wd;
  logic [31:0] mem [4];

  assign M_AXI_AWREADY = (aw_cnt >= aw_dly);
  assign M_AXI_WREADY  = (w_cnt >= w_dly);
  assign M_AXI_ARREADY = (ar_cnt >= ar_dly);

  initial for (int i = 0; i < 4; i++) mem[i] = 32'h0;

  always @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
      s_awa <= '0; s_ara <= '0; s_wd <= '0;
      M_AXI_BVALID <= 1'b0; M_AXI_BRESP <= 2'b00;
      M_AXI_RVALID <= 1'b0; M_AXI_RRESP <= 2'b00;
      M_AXI_RDATA <= '0;
    end else begin
      aw_cnt <= (M_AXI_AWVALID && !M_AXI_AWREADY) ? aw_cnt + 1 : 0;
      w_cnt  <= (M_AXI_WVALID && !M_AXI_WREADY) ? w_cnt + 1 : 0;
      ar_cnt <= (M_AXI_ARVALID && !M_AXI_ARREADY) ? ar_cnt + 1 : 0;
      if (M_AXI_AWVALID && M_AXI_AWREADY) begin
        aw_got <= 1'b1; s_awa <= M_AXI_AWADDR;
      end
      if (M_AXI_WVALID && M_AXI_WREADY) begin
        w_got <= 1'b1; s_wd <= M_AXI_WDATA;
      end
      if (aw_got && w_got && !M_AXI_BVALID) begin
        M_AXI_BVALID <= 1'b1; M_AXI_BRESP <= 2'b00;
        mem[s_awa[3:2]] <= s_wd;
        aw_got <= 1'b0; w_got <= 1'b0;
      end
      if (M_AXI_BVALID && M_AXI_BREADY) M_AXI_BVALID <= 1'b0;
      if (M_AXI_ARVALID && M_AXI_ARREADY) begin
        ar_got <= 1'b1; s_ara <= M_AXI_ARADDR;
      end
      if (ar_got && !M_AXI_RVALID) begin
        M_AXI_RVALID <= 1'b1;
        M_AXI_RDATA  <= err_mode ? 32'hDEAD : mem[s_ara[3:2]];
        M_AXI_RRESP  <= err_mode ? 2'b10 : 2'b00;
        ar_got <= 1'b0;
      end
      if (M_AXI_RVALID && M_AXI_RREADY) M_AXI_RVALID <= 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  // One access by requester idx; returns ack latency and channel statistics.
  task automatic run_one(input int idx, input logic w, input logic [3:0] a,
                         input logic [31:0] d, output int lat,
                         output logic [1:0] ackv, output logic [31:0] rd,
                         output logic [1:0] rs, output int naw, output int nw,
                         output int nar, output int dlt, output int wbad);
    int rsp_at;
    lat = -1; ackv = '0; rd = '0; rs = '0;
    naw = 0; nw = 0; nar = 0; dlt = -1; wbad = 0; rsp_at = -100;
    @(negedge ACLK);
    req[idx] = 1'b1; we[idx] = w;
    addr[idx*4 +: 4] = a; wdata[idx*32 +: 32] = d;
    @(posedge ACLK);
    for (int n = 1; n <= 60; n++) begin
      @(negedge ACLK);
      if (M_AXI_AWVALID) naw++;
      if (M_AXI_WVALID) begin
        nw++;
        if (M_AXI_WDATA !== d) wbad++;
      end
      if (M_AXI_ARVALID) nar++;
      if ((M_AXI_BVALID && M_AXI_BREADY) || (M_AXI_RVALID && M_AXI_RREADY))
        rsp_at = n;
      if (ack != 2'b00) begin
        lat = n; ackv = ack; rd = rdata; rs = resp;
        dlt = n - rsp_at;
        req[idx] = 1'b0;
        break;
      end
    end
    if (lat < 0) req[idx] = 1'b0;
  endtask

  task automatic wait_ack(output logic got);
    got = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(negedge ACLK);
      if (ack != 2'b00) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    int          idx;
    logic        w;
    logic [3:0]  a;
    logic [31:0] d;
    logic        err;
    logic [31:0] xrd;
    logic [1:0]  xrs;
  } vec_t;

  vec_t vt [10];

  initial begin
    int          lat, naw, nw, nar, dlt, wbad;
    logic [1:0]  ackv, rs;
    logic [31:0] rd;
    logic        got;

    vt[0] = '{0, 1'b1, 4'h0, 32'h1, 1'b0, 32'h0, 2'b00};
    vt[1] = '{0, 1'b1, 4'h4, 32'h2, 1'b0, 32'h0, 2'b00};
    vt[2] = '{0, 1'b1, 4'h8, 32'h3, 1'b0, 32'h0, 2'b00};
    vt[3] = '{0, 1'b1, 4'hC, 32'h4, 1'b0, 32'h0, 2'b00};
    vt[4] = '{0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h1, 2'b00};
    vt[5] = '{0, 1'b0, 4'h4, 32'h0, 1'b0, 32'h2, 2'b00};
    vt[6] = '{0, 1'b0, 4'h8, 32'h0, 1'b0, 32'h3, 2'b00};
    vt[7] = '{0, 1'b0, 4'hC, 32'h0, 1'b0, 32'h4, 2'b00};
    vt[8] = '{1, 1'b0, 4'h8, 32'h0, 1'b1, 32'hDEAD, 2'b10};
    vt[9] = '{1, 1'b0, 4'hC, 32'h0, 1'b0, 32'h4, 2'b00};

    ARESET = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
    #1;
    chk("rst_ack", 32'(ack), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_valids", 32'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID}), 0);
    chk("rst_readys", 32'({M_AXI_BREADY, M_AXI_RREADY}), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_resp", 32'(resp), 0);
    @(negedge ACLK); @(negedge ACLK);
    ARESET = 1'b0;

    for (int k = 0; k < 10; k++) begin
      err_mode = vt[k].err;
      run_one(vt[k].idx, vt[k].w, vt[k].a, vt[k].d,
              lat, ackv, rd, rs, naw, nw, nar, dlt, wbad);
      err_mode = 1'b0;
      chk($sformatf("v%0d_ack", k), 32'(ackv), 32'(2'b01 << vt[k].idx));
      chk($sformatf("v%0d_lat", k), 32'(lat), 4);
      chk($sformatf("v%0d_rdata", k), rd, vt[k].xrd);
      chk($sformatf("v%0d_resp", k), 32'(rs), 32'(vt[k].xrs));
    end

    // Both requesters pending from reset: r0 writes, r1 reads, alternating.
    @(negedge ACLK);
    ARESET = 1'b1;
    req = 2'b11; we = 2'b01;
    addr = {4'h4, 4'h0}; wdata = {32'h0, 32'hA};
    @(negedge ACLK);
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("simul_first_grant", 32'(grant), 32'(2'b01));
    for (int k = 0; k < 4; k++) begin
      wait_ack(got);
      chk($sformatf("alt%0d_ack", k), 32'(ack), (k % 2) ? 32'h2 : 32'h1);
      chk($sformatf("alt%0d_rdata", k), rdata, (k % 2) ? 32'h2 : 32'h0);
    end
    req = 2'b00;

    // Write backpressure: AWREADY one cycle late, WREADY three.
    aw_dly = 1; w_dly = 3;
    run_one(0, 1'b1, 4'h8, 32'h77, lat, ackv, rd, rs, naw, nw, nar, dlt, wbad);
    aw_dly = 0; w_dly = 0;
    chk("bp_aw_cycles", 32'(naw), 2);
    chk("bp_w_cycles", 32'(nw), 4);
    chk("bp_wdata_stable", 32'(wbad), 0);
    chk("bp_ack_after_b", 32'(dlt), 1);
    chk("bp_ack", 32'(ackv), 32'(2'b01));
    chk("bp_resp", 32'(rs), 0);

    // Reset while r1's write sits in WRESP; pointer was 1 before it.
    @(negedge ACLK);
    req = 2'b10; we = 2'b10; addr[7:4] = 4'h8; wdata[63:32] = 32'h55;
    for (int n = 0; n < 20; n++) begin
      @(negedge ACLK);
      if (M_AXI_BREADY) break;
    end
    chk("mid_in_wresp", 32'(M_AXI_BREADY), 1);
    ARESET = 1'b1;
    #1;
    chk("mid_ack", 32'(ack), 0);
    chk("mid_grant", 32'(grant), 0);
    chk("mid_bready", 32'(M_AXI_BREADY), 0);
    chk("mid_valids", 32'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID,
                           M_AXI_RREADY}), 0);
    chk("mid_rdata", rdata, 0);
    chk("mid_resp", 32'(resp), 0);
    req = 2'b00;
    @(negedge ACLK);
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("mid_no_ack", 32'(ack), 0);
    req = 2'b11; we = 2'b00; addr = {4'h4, 4'h0};
    @(negedge ACLK);
    chk("mid_ptr_grant", 32'(grant), 32'(2'b01));
    wait_ack(got);
    chk("mid_r0_ack", 32'(ack), 32'(2'b01));
    chk("mid_r0_rdata", rdata, 32'hA);
    wait_ack(got);
    chk("mid_r1_ack", 32'(ack), 32'(2'b10));
    chk("mid_r1_rdata", rdata, 32'h2);
    req = 2'b00;

`ifdef AXIL_ARB_TIMEOUT_EN
    ar_dly = 100000;
    run_one(0, 1'b0, 4'hC, 32'h0, lat, ackv, rd, rs, naw, nw, nar, dlt, wbad);
    ar_dly = 0;
    chk("tmo_ar_cycles", 32'(nar), 16);
    chk("tmo_ack", 32'(ackv), 32'(2'b01));
    chk("tmo_resp", 32'(rs), 32'(2'b10));
    chk("tmo_rdata", rd, 0);
`endif

    @(negedge ACLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
